// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO stack with replace-top, empty bypass, peek,
// occupancy count, almost-full threshold and sticky overflow/underflow flags.
module lifo_stack_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AFULL = 12,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [WIDTH-1:0] top_out,
  output logic [CW-1:0]    last,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic [CW-1:0]    r_last;
  logic             r_empty;
  logic             r_full;
  logic             r_afull;
  logic             r_ovf;
  logic             r_udf;

  logic             w_do_push;
  logic             w_do_pop;
  logic             w_replace;
  logic             w_bypass;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic [CW-1:0]    w_last_nxt;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_mem_we;
  logic [WIDTH-1:0] w_top;

  // Operation decode from {push,pop} and the pre-edge occupancy flags
  always_comb begin
    w_do_push  = push & ~pop & ~r_full;
    w_do_pop   = pop & ~push & ~r_empty;
    w_replace  = push & pop & ~r_empty;
    w_bypass   = push & pop & r_empty;
    w_ovf_evt  = push & ~pop & r_full;
    w_udf_evt  = pop & ~push & r_empty;
    w_last_nxt = r_last;
    if (w_do_push) begin
      w_last_nxt = r_last + CW'(1);
    end else if (w_do_pop) begin
      w_last_nxt = r_last - CW'(1);
    end
  end

  always_comb begin
    w_top_idx = AW'(r_last - CW'(1));
    w_wr_idx  = w_replace ? w_top_idx : AW'(r_last);
    w_mem_we  = w_do_push | w_replace;
    w_top     = r_mem[w_top_idx];
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_last   <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_do_pop || w_replace) begin
        r_dout <= w_top;
      end else if (w_bypass) begin
        r_dout <= data_in;
      end
      r_dvalid <= w_do_pop | w_replace | w_bypass;
      r_last   <= w_last_nxt;
      r_empty  <= (w_last_nxt == CW'(0));
      r_full   <= (w_last_nxt == CW'(DEPTH));
      r_afull  <= (w_last_nxt >= CW'(AFULL));
      // A new error event wins over a coincident clear
      r_ovf    <= w_ovf_evt | (r_ovf & ~clear_err);
      r_udf    <= w_udf_evt | (r_udf & ~clear_err);
    end
  end

  assign data_out    = r_dout;
  assign data_valid  = r_dvalid;
  assign top_out     = r_empty ? '0 : w_top;
  assign last        = r_last;
  assign empty       = r_empty;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign overflow    = r_ovf;
  assign underflow   = r_udf;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed bench for lifo_stack_param (WIDTH=32, DEPTH=16, AFULL=12).
module tb_lifo_stack_param;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic [31:0] data_in;
  logic        clear_err;
  logic [31:0] data_out;
  logic        data_valid;
  logic [31:0] top_out;
  logic [4:0]  last;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  lifo_stack_param #(.WIDTH(32), .DEPTH(16), .AFULL(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .clear_err   (clear_err),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .top_out     (top_out),
    .last        (last),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic p, input logic q, input logic [31:0] d);
    push    = p;
    pop     = q;
    data_in = d;
    tick();
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
  endtask

  task automatic chk_idle_state(input string tag);
    chk_word({tag, "_last"}, 32'(last), 32'd0);
    chk_bit ({tag, "_empty"}, empty, 1'b1);
    chk_bit ({tag, "_full"}, full, 1'b0);
    chk_bit ({tag, "_dv"}, data_valid, 1'b0);
    chk_word({tag, "_dout"}, data_out, 32'd0);
    chk_bit ({tag, "_ovf"}, overflow, 1'b0);
    chk_bit ({tag, "_udf"}, underflow, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    data_in   = '0;
    clear_err = 1'b0;

    // Reset held, then idle
    tick();
    tick();
    chk_idle_state("reset");
    chk_bit("reset_afull", almost_full, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle_state("idle");
    end

    // Fill 1..16
    for (int i = 1; i <= 16; i++) begin
      op(1'b1, 1'b0, 32'(i));
      chk_word("fill_last", 32'(last), 32'(i));
      chk_word("fill_top", top_out, 32'(i));
      chk_bit ("fill_afull", almost_full, (i >= 12));
      chk_bit ("fill_full", full, (i == 16));
      chk_bit ("fill_empty", empty, 1'b0);
    end

    // Overflow on full stack
    op(1'b1, 1'b0, 32'd99);
    chk_word("ovf_last", 32'(last), 32'd16);
    chk_word("ovf_top", top_out, 32'd16);
    chk_bit ("ovf_flag", overflow, 1'b1);
    chk_bit ("ovf_full", full, 1'b1);

    // Drain 16..1
    for (int i = 16; i >= 1; i--) begin
      op(1'b0, 1'b1, 32'd0);
      chk_word("drain_dout", data_out, 32'(i));
      chk_bit ("drain_dv", data_valid, 1'b1);
      chk_word("drain_last", 32'(last), 32'(i - 1));
      chk_bit ("drain_afull", almost_full, (i - 1 >= 12));
    end
    chk_bit("drain_empty", empty, 1'b1);
    chk_bit("drain_ovf_sticky", overflow, 1'b1);
    chk_word("drain_top_empty", top_out, 32'd0);

    // Underflow
    op(1'b0, 1'b1, 32'd0);
    chk_bit ("udf_flag", underflow, 1'b1);
    chk_bit ("udf_dv", data_valid, 1'b0);
    chk_word("udf_dout", data_out, 32'd1);

    // Clear errors
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk_bit("clr_ovf", overflow, 1'b0);
    chk_bit("clr_udf", underflow, 1'b0);

    // Error wins over coincident clear
    clear_err = 1'b1;
    op(1'b0, 1'b1, 32'd0);
    clear_err = 1'b0;
    chk_bit("errwin_udf", underflow, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk_bit("errwin_clr", underflow, 1'b0);

    // Replace-top
    op(1'b1, 1'b0, 32'd5);
    op(1'b1, 1'b0, 32'd6);
    op(1'b1, 1'b1, 32'd7);
    chk_word("rep_dout", data_out, 32'd6);
    chk_bit ("rep_dv", data_valid, 1'b1);
    chk_word("rep_last", 32'(last), 32'd2);
    chk_word("rep_top", top_out, 32'd7);
    op(1'b0, 1'b1, 32'd0);
    chk_word("rep_pop_dout", data_out, 32'd7);
    chk_word("rep_pop_top", top_out, 32'd5);
    op(1'b0, 1'b1, 32'd0);
    chk_word("rep_pop2_dout", data_out, 32'd5);
    chk_bit ("rep_pop2_empty", empty, 1'b1);
    tick();
    chk_bit ("rep_dv_pulse", data_valid, 1'b0);
    chk_word("rep_dout_hold", data_out, 32'd5);

    // Empty bypass
    op(1'b1, 1'b1, 32'hA5A5_A5A5);
    chk_word("byp_dout", data_out, 32'hA5A5_A5A5);
    chk_bit ("byp_dv", data_valid, 1'b1);
    chk_word("byp_last", 32'(last), 32'd0);
    chk_bit ("byp_empty", empty, 1'b1);
    chk_bit ("byp_udf", underflow, 1'b0);
    chk_word("byp_top", top_out, 32'd0);

    // Async reset mid-fill
    op(1'b1, 1'b0, 32'd11);
    op(1'b1, 1'b0, 32'd22);
    op(1'b1, 1'b0, 32'd33);
    chk_word("arst_pre_last", 32'(last), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_word("arst_last", 32'(last), 32'd0);
    chk_bit ("arst_empty", empty, 1'b1);
    chk_word("arst_dout", data_out, 32'd0);
    #1;
    reset = 1'b1;
    op(1'b0, 1'b1, 32'd0);
    chk_bit("arst_udf", underflow, 1'b1);
    chk_bit("arst_dv", data_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
